// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
//
// General-purpose register file for the MIPS core with a pending-write
// scoreboard. It has two asynchronous read ports and one synchronous write
// port. Each register has a pending flag. A multi-cycle unit sets the flag
// when it issues and the writeback clears it.
//
// Parameters:
//   DATA_W   - register width in bits
//   ADDR_W   - address width; depth is 2**ADDR_W
//   ZERO_REG - nonzero: register 0 reads 0, drops writes/issues, never pending
//
// Ports:
//   clk, reset         - rising-edge clock, synchronous active-high reset
//   ra1/ra2            - read addresses (rs / rt)
//   rd1/rd2            - read data (combinational)
//   busy1/busy2        - pending flag of ra1/ra2 (combinational)
//   we3/wa3/wd3        - write enable / address / data
//   iss_en/iss_addr    - mark iss_addr pending at the next edge
//   any_busy           - OR of all stored pending flags
//
// Optional build macro:
//   REGFILE_BYPASS_EN  - same-cycle write-through from port 3 to rd*/busy*
// -----------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy1,
    output logic              busy2,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              any_busy
);

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam bit ZERO_EN = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [DEPTH-1:0]  pend_r;

    logic              wr_ok_s;
    logic              iss_ok_s;
    logic [DEPTH-1:0]  pend_clr_s;
    logic [DEPTH-1:0]  pend_set_s;
    logic [DEPTH-1:0]  pend_next_s;
    logic [DATA_W-1:0] rd1_st_s;
    logic [DATA_W-1:0] rd2_st_s;
    logic              busy1_st_s;
    logic              busy2_st_s;

    // Qualify write/issue against the hardwired zero register.
    always_comb begin
        wr_ok_s  = we3 && !(ZERO_EN && (wa3 == {ADDR_W{1'b0}}));
        iss_ok_s = iss_en && !(ZERO_EN && (iss_addr == {ADDR_W{1'b0}}));
    end

    // Pending update: clear on write, then set on issue so that a same-address
    // issue overrides the clear (the newer producer still owns the register).
    always_comb begin
        pend_clr_s  = wr_ok_s  ? ({{(DEPTH-1){1'b0}}, 1'b1} << wa3)      : {DEPTH{1'b0}};
        pend_set_s  = iss_ok_s ? ({{(DEPTH-1){1'b0}}, 1'b1} << iss_addr) : {DEPTH{1'b0}};
        pend_next_s = (pend_r & ~pend_clr_s) | pend_set_s;
    end

    // Register storage: synchronous reset clears everything; reset blocks writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_ok_s) begin
            regs_r[wa3] <= wd3;
        end
    end

    // Scoreboard flags: reset discards all outstanding pending state.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_r <= {DEPTH{1'b0}};
        end else begin
            pend_r <= pend_next_s;
        end
    end

    // Stored-state read view, with address 0 forced to zero when hardwired.
    always_comb begin
        rd1_st_s   = (ZERO_EN && (ra1 == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : regs_r[ra1];
        rd2_st_s   = (ZERO_EN && (ra2 == {ADDR_W{1'b0}})) ? {DATA_W{1'b0}} : regs_r[ra2];
        busy1_st_s = (ZERO_EN && (ra1 == {ADDR_W{1'b0}})) ? 1'b0 : pend_r[ra1];
        busy2_st_s = (ZERO_EN && (ra2 == {ADDR_W{1'b0}})) ? 1'b0 : pend_r[ra2];
    end

`ifdef REGFILE_BYPASS_EN
    // Write-through: a write in flight to a read address is visible at once;
    // busy reflects only a same-cycle issue to that same register.
    always_comb begin
        rd1   = rd1_st_s;
        rd2   = rd2_st_s;
        busy1 = busy1_st_s;
        busy2 = busy2_st_s;
        if (wr_ok_s && (wa3 == ra1)) begin
            rd1   = wd3;
            busy1 = iss_ok_s && (iss_addr == wa3);
        end else begin
            rd1   = rd1_st_s;
            busy1 = busy1_st_s;
        end
        if (wr_ok_s && (wa3 == ra2)) begin
            rd2   = wd3;
            busy2 = iss_ok_s && (iss_addr == wa3);
        end else begin
            rd2   = rd2_st_s;
            busy2 = busy2_st_s;
        end
    end
`else
    // Reads reflect stored state only; a write shows up one cycle later.
    always_comb begin
        rd1   = rd1_st_s;
        rd2   = rd2_st_s;
        busy1 = busy1_st_s;
        busy2 = busy2_st_s;
    end
`endif

    // any_busy comes from stored flags only, so it has no path from we3/iss_en.
    always_comb begin
        any_busy = |pend_r;
    end

endmodule
